// File: rtl/fwrisc_bus_arb.sv
// Two-port arbiter: fetch and data requesters share one memory port. Optional round-robin tie-break via FWRISC_BUS_ARB_RR_EN (default: data beats fetch).
// Latency: grant one cycle after the request is sampled in IDLE; ready is combinational from m_ready, or forced with err after TIMEOUT busy cycles.
// Backpressure: the requester holds valid and payload until ready; the port is held until m_ready or the watchdog expires.
module fwrisc_bus_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ivalid,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    output logic        iready,
    output logic        ierr,
    input  logic        dvalid,
    input  logic [31:0] daddr,
    input  logic        dwrite,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        derr,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic        m_write,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstb,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic        TO_EN   = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        busy;
    logic        expire;
    logic        done;
    logic        tie_to_data;

    always_comb begin
        busy        = (state_q != IDLE);
        expire      = TO_EN && busy && (cnt_q == TO_LAST) && !m_ready;
        done        = busy && (m_ready || expire);
`ifdef FWRISC_BUS_ARB_RR_EN
        tie_to_data = !last_grant_q;
`else
        tie_to_data = 1'b1;
`endif
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                // Counter is cleared here so every grant enters BUSY at zero.
                cnt_d = 16'd0;
                if (ivalid && dvalid) begin
                    state_d      = tie_to_data ? BUSY_D : BUSY_I;
                    last_grant_d = tie_to_data;
                end else if (ivalid) begin
                    state_d      = BUSY_I;
                    last_grant_d = 1'b0;
                end else if (dvalid) begin
                    state_d      = BUSY_D;
                    last_grant_d = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_comb begin
        m_valid = busy;
        m_addr  = 32'd0;
        m_write = 1'b0;
        m_wdata = 32'd0;
        m_wstb  = 4'd0;
        if (state_q == BUSY_I) begin
            m_addr = iaddr;
        end else if (state_q == BUSY_D) begin
            m_addr  = daddr;
            m_write = dwrite;
            m_wdata = dwdata;
            m_wstb  = dwstb;
        end

        // A reset cycle never completes a transaction.
        iready = (state_q == BUSY_I) && done && !reset;
        dready = (state_q == BUSY_D) && done && !reset;
        ierr   = iready && expire;
        derr   = dready && expire;
        idata  = ((state_q == BUSY_I) && expire) ? 32'd0 : m_rdata;
        drdata = ((state_q == BUSY_D) && expire) ? 32'd0 : m_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
